writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Write-back stage directly upstream of the register file. Accepts retired instructions from
//  execute over a valid/ready handshake, waits on variable-latency data memory for loads, and
//  sign/zero-extends load data. Selects the result source (ALU, load, PC+4) and drives one
//  registered write port (rd, RUWr, resultado) into the register file.
// PARAMETERS
//  XLEN        32   datapath width
//  LD_TIMEOUT  16   max cycles in WAIT_LD before abort; >=1
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     reset, asynchronous, active-low
//  in_valid     in   1     execute presents an instruction
//  in_ready     out  1     unit can accept (combinational from state)
//  in_rd        in   5     destination register
//  in_ruwr      in   1     instruction writes rd
//  in_wbsrc     in   2     00 ALU, 01 load, 10 PC+4, 11 reserved (no write)
//  in_alu       in   XLEN  ALU result; low 2 bits = load byte address
//  in_pc4       in   XLEN  PC+4
//  in_funct3    in   3     load type
//  dm_rvalid    in   1     data memory read data valid (1-cycle pulse)
//  dm_rdata     in   XLEN  word-aligned read data
//  rd           out  5     to register file
//  RUWr         out  1     register file write enable (1-cycle pulse)
//  resultado    out  XLEN  write data
//  ld_err       out  1     sticky: misaligned/illegal load or timeout
// BEHAVIOUR
//  States: IDLE, WAIT_LD. in_ready=1 only in IDLE. Accept = in_valid & in_ready.
//  Reset (async, rst_n=0): state IDLE, rd=0, RUWr=0, resultado=0, ld_err=0, timeout count=0.
//  Reset mid-load drops the load; a later dm_rvalid while IDLE is ignored.
//  Accept non-load in cycle N -> rd/resultado/RUWr valid in N+1; back-to-back every cycle.
//  RUWr = in_ruwr & (in_rd!=0) & (wbsrc!=11); rd==0 never writes.
//  Accept load (wbsrc=01) -> WAIT_LD, in_alu[1:0] and funct3 latched; RUWr=0 while waiting.
//  WAIT_LD: dm_rvalid in cycle M -> extended data written in M+1; state IDLE in M+1.
//  Extension: LB 000, LH 001 sign-extend; LW 010; LBU 100, LHU 101 zero-extend.
//   Byte lane = addr[1:0]; half lane = addr[1].
//  Misaligned (LH/LHU addr[0]=1, LW addr[1:0]!=0) or funct3 in {011,110,111}:
//   detected at accept; no memory wait, no write, ld_err<=1, stay IDLE.
//  Timeout counter clears on entry to WAIT_LD and counts in WAIT_LD.
//   At LD_TIMEOUT cycles without dm_rvalid: ld_err<=1, no write, return to IDLE.
//   dm_rvalid in the same cycle as the timeout: data wins, write occurs.
//  ld_err clears only on reset.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: adds output retire_cnt [63:0], reset 0.
//   Increments once per completed instruction, including rd==0, wbsrc=11 and erroneous loads.
//   Wraps modulo 2^64.
//  Undefined: port and counter absent; otherwise identical.
// STRUCTURE
//  Package riscv_pkg: wb_src_t enum (WB_ALU, WB_LOAD, WB_PC4, WB_NONE),
//   load funct3 localparams (F3_LB..F3_LHU), wb_state_t enum (IDLE, WAIT_LD).
//  Sub-module load_extender: combinational; (rdata, addr[1:0], funct3) -> ext_data, misalign, illegal.
// TESTING
//  ALU op rd=5 in_alu=0x1234 accepted N -> N+1 rd=5 RUWr=1 resultado=0x1234; next cycle RUWr=0.
//  PC4 rd=0 in_ruwr=1 -> RUWr stays 0; 3 back-to-back ALU ops -> 3 consecutive RUWr pulses.
//  LB addr=..03, dm_rdata=0x80FF_0000 after 4 cycles -> in_ready=0 while waiting;
//   resultado=0xFFFF_FF80; LBU same data -> 0x0000_0080.
//  LH at addr ..01 -> no write, ld_err=1, in_ready stays 1.
//  Load with no dm_rvalid -> after 16 cycles ld_err=1, no write, IDLE.
//   Repeat with dm_rvalid on cycle 16 -> write occurs.
//  rst_n low during WAIT_LD then dm_rvalid after release -> no write, all outputs 0.
//   With WB_RETIRE_CNT_EN: retire_cnt=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the write-back stage: result-source encoding,
// load funct3 codes and the write-back FSM state type.
package riscv_pkg;

    // Result source selected by execute for each retired instruction.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_src_t;

    // Load funct3 encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Write-back FSM states.
    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } wb_state_t;

    // True for funct3 codes that do not name a load (011, 110, 111).
    function automatic logic f3_is_illegal(input logic [2:0] f3);
        return !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load alignment and extension. Picks the addressed byte/half
// out of a word-aligned read word, sign- or zero-extends it, and flags
// misaligned accesses and non-load funct3 codes.
module load_extender
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] ext_data_o,
    output logic            misalign_o,
    output logic            illegal_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane selection: byte lane from addr[1:0], half lane from addr[1].
    always_comb begin
        byte_v = 8'h00;
        case (addr_i)
            2'd0: byte_v = rdata_i[7:0];
            2'd1: byte_v = rdata_i[15:8];
            2'd2: byte_v = rdata_i[23:16];
            2'd3: byte_v = rdata_i[31:24];
            default: byte_v = 8'h00;
        endcase
        half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension and error classification by load type.
    always_comb begin
        ext_data_o = '0;
        misalign_o = 1'b0;
        illegal_o  = f3_is_illegal(funct3_i);
        case (funct3_i)
            F3_LB:  ext_data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU: ext_data_o = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                ext_data_o = {{(XLEN-16){half_v[15]}}, half_v};
                misalign_o = addr_i[0];
            end
            F3_LHU: begin
                ext_data_o = {{(XLEN-16){1'b0}}, half_v};
                misalign_o = addr_i[0];
            end
            F3_LW: begin
                ext_data_o = rdata_i;
                misalign_o = (addr_i != 2'b00);
            end
            default: ext_data_o = '0;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage feeding the register file. Non-load results are written
// the cycle after acceptance; loads wait for data memory (bounded by
// LD_TIMEOUT) and are extended by load_extender. ld_err is sticky.
// Optional feature: define WB_RETIRE_CNT_EN to add the 64-bit retire_cnt port.
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LD_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_ruwr,
    input  logic [1:0]      in_wbsrc,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [2:0]      in_funct3,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    output logic [4:0]      rd,
    output logic            RUWr,
    output logic [XLEN-1:0] resultado,
    output logic            ld_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]     retire_cnt
`endif
);

    localparam int unsigned CntW = $clog2(LD_TIMEOUT + 1);
    localparam logic [CntW-1:0] TmoLast = CntW'(LD_TIMEOUT - 1);

    wb_state_t       state_q;
    logic [1:0]      ld_addr_q;
    logic [2:0]      ld_f3_q;
    logic [4:0]      ld_rd_q;
    logic            ld_ruwr_q;
    logic [CntW-1:0] tmo_cnt_q;
    logic [4:0]      rd_q;
    logic            ruwr_q;
    logic [XLEN-1:0] res_q;
    logic            err_q;

    wb_src_t         src;
    logic            accept;
    logic [1:0]      ext_addr;
    logic [2:0]      ext_f3;
    logic [XLEN-1:0] ext_data;
    logic            ext_misalign;
    logic            ext_illegal;
    logic            ld_bad;
    logic            tmo_hit;
    logic            retire_now;
    logic [XLEN-1:0] nonload_res;

    // Handshake, extender input steering and completion detection.
    // While idle the extender classifies the incoming load; while waiting it
    // extends the returned word using the latched address and type.
    always_comb begin
        src         = wb_src_t'(in_wbsrc);
        in_ready    = (state_q == IDLE);
        accept      = in_valid & in_ready;
        ext_addr    = (state_q == WAIT_LD) ? ld_addr_q : in_alu[1:0];
        ext_f3      = (state_q == WAIT_LD) ? ld_f3_q : in_funct3;
        ld_bad      = ext_misalign | ext_illegal;
        tmo_hit     = (tmo_cnt_q == TmoLast);
        nonload_res = '0;
        case (src)
            WB_ALU:  nonload_res = in_alu;
            WB_PC4:  nonload_res = in_pc4;
            default: nonload_res = '0;
        endcase
        retire_now = (accept & ((src != WB_LOAD) | ld_bad))
                   | ((state_q == WAIT_LD) & (dm_rvalid | tmo_hit));
    end

    load_extender #(
        .XLEN(XLEN)
    ) u_load_extender (
        .rdata_i    (dm_rdata),
        .addr_i     (ext_addr),
        .funct3_i   (ext_f3),
        .ext_data_o (ext_data),
        .misalign_o (ext_misalign),
        .illegal_o  (ext_illegal)
    );

    // FSM with registered write port; RUWr is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ld_addr_q <= 2'b00;
            ld_f3_q   <= 3'b000;
            ld_rd_q   <= 5'd0;
            ld_ruwr_q <= 1'b0;
            tmo_cnt_q <= '0;
            rd_q      <= 5'd0;
            ruwr_q    <= 1'b0;
            res_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            ruwr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (src == WB_LOAD) begin
                            if (ld_bad) begin
                                err_q <= 1'b1;
                            end else begin
                                state_q   <= WAIT_LD;
                                ld_addr_q <= in_alu[1:0];
                                ld_f3_q   <= in_funct3;
                                ld_rd_q   <= in_rd;
                                ld_ruwr_q <= in_ruwr;
                                tmo_cnt_q <= '0;
                            end
                        end else begin
                            rd_q   <= in_rd;
                            res_q  <= nonload_res;
                            ruwr_q <= in_ruwr & (in_rd != 5'd0) & (src != WB_NONE);
                        end
                    end
                end
                WAIT_LD: begin
                    // Data arriving in the timeout cycle still completes the load.
                    if (dm_rvalid) begin
                        state_q <= IDLE;
                        rd_q    <= ld_rd_q;
                        res_q   <= ext_data;
                        ruwr_q  <= ld_ruwr_q & (ld_rd_q != 5'd0);
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd        = rd_q;
        RUWr      = ruwr_q;
        resultado = res_q;
        ld_err    = err_q;
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_q;

    // Count every completed instruction, including non-writing and failed ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= 64'd0;
        end else if (retire_now) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    assign retire_cnt = retire_q;
`else
    logic unused_retire;
    assign unused_retire = retire_now;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by
// randomized transactions checked against a behavioural model.
module tb_writeback_unit;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned LdTimeout = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      in_rd = '0;
    logic            in_ruwr = 1'b0;
    logic [1:0]      in_wbsrc = '0;
    logic [XLEN-1:0] in_alu = '0;
    logic [XLEN-1:0] in_pc4 = '0;
    logic [2:0]      in_funct3 = '0;
    logic            dm_rvalid = 1'b0;
    logic [XLEN-1:0] dm_rdata = '0;
    logic [4:0]      rd;
    logic            RUWr;
    logic [XLEN-1:0] resultado;
    logic            ld_err;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]     retire_cnt;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic exp_err = 1'b0;
    longint unsigned exp_ret = 0;

    writeback_unit #(
        .XLEN       (XLEN),
        .LD_TIMEOUT (LdTimeout)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_ruwr   (in_ruwr),
        .in_wbsrc  (in_wbsrc),
        .in_alu    (in_alu),
        .in_pc4    (in_pc4),
        .in_funct3 (in_funct3),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .rd        (rd),
        .RUWr      (RUWr),
        .resultado (resultado),
        .ld_err    (ld_err)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference extension: pick the lane arithmetically, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit model_bad(input logic [2:0] f3, input logic [1:0] a);
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_side(input string tag);
        check_eq({tag, "_err"}, ld_err, exp_err);
`ifdef WB_RETIRE_CNT_EN
        check_eq({tag, "_ret"}, retire_cnt, exp_ret);
`endif
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 with DUT idle.
    task automatic do_reset();
        in_valid  = 1'b0;
        dm_rvalid = 1'b0;
        rst_n     = 1'b0;
        exp_err   = 1'b0;
        exp_ret   = 0;
        #1;
        check_eq("rst_rd", rd, 0);
        check_eq("rst_ruwr", RUWr, 0);
        check_eq("rst_res", resultado, 0);
        check_side("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_ready", in_ready, 1);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_ruwr", RUWr, 0);
    endtask

    // One transaction; lat = wait cycle in which dm_rvalid pulses
    // (lat > LdTimeout means the data never arrives).
    task automatic run_txn(input logic [4:0] t_rd, input logic t_ruwr, input logic [1:0] t_src,
                           input logic [31:0] t_alu, input logic [31:0] t_pc4,
                           input logic [2:0] t_f3, input logic [31:0] t_data, input int lat);
        bit exp_w;
        check_eq("start_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_rd     = t_rd;
        in_ruwr   = t_ruwr;
        in_wbsrc  = t_src;
        in_alu    = t_alu;
        in_pc4    = t_pc4;
        in_funct3 = t_f3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (t_src != 2'b01) begin
            exp_ret++;
            exp_w = t_ruwr && (t_rd != 0) && (t_src != 2'b11);
            check_eq("nl_ruwr", RUWr, exp_w);
            if (exp_w) begin
                check_eq("nl_rd", rd, t_rd);
                check_eq("nl_res", resultado, (t_src == 2'b00) ? t_alu : t_pc4);
            end
            check_side("nl");
        end else if (model_bad(t_f3, t_alu[1:0])) begin
            exp_ret++;
            exp_err = 1'b1;
            check_eq("bad_ruwr", RUWr, 0);
            check_eq("bad_ready", in_ready, 1);
            check_side("bad");
        end else begin
            for (int k = 1; k <= int'(LdTimeout); k++) begin
                check_eq("wait_ready", in_ready, 0);
                check_eq("wait_ruwr", RUWr, 0);
                check_eq("wait_err", ld_err, exp_err);
                if (k == lat) begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = t_data;
                end else begin
                    dm_rdata = $urandom;
                end
                @(posedge clk);
                #1;
                dm_rvalid = 1'b0;
                if (k == lat) begin
                    exp_ret++;
                    exp_w = t_ruwr && (t_rd != 0);
                    check_eq("ld_ruwr", RUWr, exp_w);
                    if (exp_w) begin
                        check_eq("ld_rd", rd, t_rd);
                        check_eq("ld_res", resultado, model_load(t_f3, t_alu[1:0], t_data));
                    end
                    check_eq("ld_ready", in_ready, 1);
                    check_side("ld");
                    break;
                end
                if (k == int'(LdTimeout)) begin
                    exp_ret++;
                    exp_err = 1'b1;
                    check_eq("tmo_ruwr", RUWr, 0);
                    check_eq("tmo_ready", in_ready, 1);
                    check_side("tmo");
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Single ALU op, then an idle cycle with no write.
        run_txn(5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 3'd0, 32'h0, 1);
        check_eq("alu_res_const", resultado, 32'h1234);
        idle_cycle();

        // PC+4 to x0 never writes.
        run_txn(5'd0, 1'b1, 2'b10, 32'h0, 32'h100, 3'd0, 32'h0, 1);
        // Three back-to-back ALU ops.
        for (int i = 0; i < 3; i++) begin
            run_txn(5'(i + 1), 1'b1, 2'b00, 32'hA0 + 32'(i), 32'h0, 3'd0, 32'h0, 1);
        end
        idle_cycle();

        // LB / LBU from byte 3 with data after four wait cycles.
        run_txn(5'd7, 1'b1, 2'b01, 32'h1003, 32'h0, 3'd0, 32'h80FF_0000, 4);
        check_eq("lb_const", resultado, 32'hFFFF_FF80);
        run_txn(5'd7, 1'b1, 2'b01, 32'h1003, 32'h0, 3'd4, 32'h80FF_0000, 4);
        check_eq("lbu_const", resultado, 32'h0000_0080);

        // Misaligned LH.
        run_txn(5'd8, 1'b1, 2'b01, 32'h2001, 32'h0, 3'd1, 32'h0, 1);
        check_eq("lh_mis_err", ld_err, 1);

        // Timeout with no data, then data arriving in the timeout cycle.
        do_reset();
        run_txn(5'd9, 1'b1, 2'b01, 32'h3000, 32'h0, 3'd2, 32'h0, LdTimeout + 1);
        do_reset();
        run_txn(5'd9, 1'b1, 2'b01, 32'h3000, 32'h0, 3'd2, 32'hCAFE_F00D, LdTimeout);
        check_eq("late_data_res", resultado, 32'hCAFE_F00D);

        // Reset in the middle of a load; stray data afterwards is ignored.
        in_valid  = 1'b1;
        in_rd     = 5'd10;
        in_ruwr   = 1'b1;
        in_wbsrc  = 2'b01;
        in_alu    = 32'h4000;
        in_funct3 = 3'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("midld_ready", in_ready, 0);
        do_reset();
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        dm_rvalid = 1'b0;
        check_eq("stray_ruwr", RUWr, 0);
        check_eq("stray_res", resultado, 0);
        check_eq("stray_rd", rd, 0);
        check_eq("stray_ready", in_ready, 1);
        check_side("stray");

        // Randomized traffic against the model, with periodic resets.
        for (int n = 0; n < 300; n++) begin
            logic [1:0] src;
            logic [2:0] f3;
            int lat;
            if (n % 60 == 0) do_reset();
            src = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) src = 2'b01;
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) f3 = f3 | 3'b100;
            lat = ($urandom_range(0, 9) == 0) ? int'(LdTimeout) + $urandom_range(0, 1)
                                              : $urandom_range(1, 5);
            run_txn(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), src, $urandom,
                    $urandom, f3, $urandom, lat);
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
